fc_argmax: RTL

Classification back end for the LeNet FP16 pipeline. Consumes the flat `output_channel`-wide FP16 logit bus produced by the fully connected output layer, scans it one element per clock, and reports the index and value of the largest logit. Sits directly after the FC layer: it is the reader of that layer's `outputConv` bus and produces the network's final class decision.

---
 rtl/fc_argmax_if.sv | 24 ++
 rtl/fc_argmax.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fc_argmax_if.sv
// Handshake and data bundle between the FC output layer and the argmax back end.
interface fc_argmax_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int output_channel = 10,
    parameter int IDX_WIDTH      = 4
);
    logic                                 start;
    logic [output_channel*DATA_WIDTH-1:0] logits;
    logic                                 busy;
    logic                                 done;
    logic [IDX_WIDTH-1:0]                 class_idx;
    logic [DATA_WIDTH-1:0]                max_value;
    logic                                 nan_flag;

    modport master (
        output start, logits,
        input  busy, done, class_idx, max_value, nan_flag
    );

    modport slave (
        input  start, logits,
        output busy, done, class_idx, max_value, nan_flag
    );
endinterface

// File: rtl/fc_argmax.sv
// Serial FP16 argmax: snapshots the logit bus on start, scans one element per
// clock and reports the index, raw value and NaN presence of the largest logit.
module fc_argmax #(
    parameter int DATA_WIDTH     = 16,
    parameter int output_channel = 10,
    parameter int IDX_WIDTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    fc_argmax_if.slave  bus
);
    localparam int MAN_W = 10;
    localparam int EXP_W = 5;
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(output_channel - 1);
    localparam logic [DATA_WIDTH-1:0] QNAN     = DATA_WIDTH'(16'h7E00);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  snap_q [output_channel];
    logic [IDX_WIDTH-1:0]   cnt_q;
    logic                   cand_vld_q;
    logic [DATA_WIDTH-1:0]  cand_key_q;
    logic [DATA_WIDTH-1:0]  cand_val_q;
    logic [IDX_WIDTH-1:0]   cand_idx_q;
    logic                   nan_acc_q;
    logic                   done_q;
    logic [IDX_WIDTH-1:0]   class_idx_q;
    logic [DATA_WIDTH-1:0]  max_value_q;
    logic                   nan_flag_q;

    logic [DATA_WIDTH-1:0]  elem;
    logic                   elem_nan;
    logic [DATA_WIDTH-1:0]  elem_key;
    logic                   take;
    logic                   fin_vld;
    logic [IDX_WIDTH-1:0]   fin_idx;
    logic [DATA_WIDTH-1:0]  fin_val;
    logic                   fin_nan;
    logic                   last;

    // NaN: exponent all ones with a non-zero mantissa.
    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
        return (&v[DATA_WIDTH-2 -: EXP_W]) && (|v[MAN_W-1:0]);
    endfunction

    // Map FP16 to an unsigned key whose ordering equals numeric ordering;
    // -0 is folded onto +0 so the two compare equal.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-2:0] mag;
        mag = v[DATA_WIDTH-2:0];
        if (mag == '0 || !v[DATA_WIDTH-1])
            return {1'b1, mag};
        else
            return {1'b0, ~mag};
    endfunction

    // Examine the current snapshot element and fold it into the running winner.
    always_comb begin
        elem     = snap_q[cnt_q];
        elem_nan = is_nan(elem);
        elem_key = order_key(elem);
        take     = !elem_nan && (!cand_vld_q || (elem_key > cand_key_q));
        fin_vld  = take || cand_vld_q;
        fin_idx  = take ? cnt_q : cand_idx_q;
        fin_val  = take ? elem  : cand_val_q;
        fin_nan  = nan_acc_q || elem_nan;
        last     = (cnt_q == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: start is only honoured in IDLE; a scan ends on the last element.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SCAN;
            SCAN:    if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from state.
    always_comb begin
        bus.busy = (state_q == SCAN);
    end

    // Snapshot capture and per-element candidate tracking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < output_channel; i++) snap_q[i] <= '0;
            cnt_q      <= '0;
            cand_vld_q <= 1'b0;
            cand_key_q <= '0;
            cand_val_q <= '0;
            cand_idx_q <= '0;
            nan_acc_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                for (int i = 0; i < output_channel; i++)
                    snap_q[i] <= bus.logits[i*DATA_WIDTH +: DATA_WIDTH];
                cnt_q      <= '0;
                cand_vld_q <= 1'b0;
                nan_acc_q  <= 1'b0;
            end
        end else begin
            cnt_q     <= cnt_q + IDX_WIDTH'(1);
            nan_acc_q <= fin_nan;
            if (take) begin
                cand_vld_q <= 1'b1;
                cand_key_q <= elem_key;
                cand_val_q <= elem;
                cand_idx_q <= cnt_q;
            end
        end
    end

    // Result registers: updated with a one-cycle done pulse on the last element.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q      <= 1'b0;
            class_idx_q <= '0;
            max_value_q <= '0;
            nan_flag_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == SCAN && last) begin
                done_q      <= 1'b1;
                class_idx_q <= fin_vld ? fin_idx : '0;
                max_value_q <= fin_vld ? fin_val : QNAN;
                nan_flag_q  <= fin_nan;
            end
        end
    end

    assign bus.done      = done_q;
    assign bus.class_idx = class_idx_q;
    assign bus.max_value = max_value_q;
    assign bus.nan_flag  = nan_flag_q;
endmodule
